// File: rtl/apb_regmem_pkg.sv
// rtl/apb_regmem_pkg.sv - shared types and constants for the APB register/RAM slave
package apb_regmem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef enum logic [2:0] {DEC_ID, DEC_DATA, DEC_STATUS, DEC_MEM, DEC_ERR} dec_t;

  // Register offsets in words from REG_BASE
  localparam int ID_OFS     = 0;
  localparam int DATA_OFS   = 1;
  localparam int STATUS_OFS = 2;

  localparam logic [29:0] DEFAULT_ID = {4'h0, 10'h176, 8'h5A, 8'h03};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/apb_regmem_slave_if.sv
// rtl/apb_regmem_slave_if.sv - APB4 bus bundle between master and the register/RAM slave
interface apb_regmem_slave_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/regmem_sp_ram.sv
// rtl/regmem_sp_ram.sv - single-port synchronous RAM with byte enables, no reset
module regmem_sp_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/apb_regmem_slave.sv
// rtl/apb_regmem_slave.sv - APB4 slave with ID/DATA/STATUS registers and a RAM window
// Registers complete in T1, RAM in T(MEM_WAIT+2); pslverr errors bump a clear-on-read counter.
module apb_regmem_slave
  import apb_regmem_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] REG_BASE  = 'h0100,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 'h1000,
  parameter int                MEM_WAIT  = 0,
  parameter logic [DATA_W-1:0] ID_VALUE  = DATA_W'(DEFAULT_ID)
) (
  input  logic              pclk,
  input  logic              rst_n,
  apb_regmem_slave_if.slave bus
);
  localparam int BYTES   = DATA_W / 8;
  localparam int ALIGN_W = $clog2(BYTES);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int CNT_W   = 5;

  localparam logic [ADDR_W-1:0] ID_ADDR     = REG_BASE + ADDR_W'(ID_OFS * BYTES);
  localparam logic [ADDR_W-1:0] DATA_ADDR   = REG_BASE + ADDR_W'(DATA_OFS * BYTES);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = REG_BASE + ADDR_W'(STATUS_OFS * BYTES);
  localparam logic [ADDR_W-1:0] SPAN_MASK   = ADDR_W'(MEM_DEPTH * BYTES - 1);

  state_t              state_q, state_d;
  dec_t                dec_q, dec_set;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BYTES-1:0]    strb_q;
  logic [IDX_W-1:0]    idx_q, idx_set;
  logic [CNT_W-1:0]    cnt_q;
  logic                pready_q, pslverr_q, mem_rd_q;
  logic [DATA_W-1:0]   prdata_q;
  logic [DATA_W-1:0]   data_q, data_merged;
  logic [15:0]         err_cnt_q;

  logic                setup, complete, abort;
  logic                ram_en, ram_we, ram_rd;
  logic [DATA_W-1:0]   ram_rdata;

  // Address decode, evaluated in the setup phase and latched with the request
  always_comb begin
    dec_set = DEC_ERR;
    if (bus.paddr[ALIGN_W-1:0] == '0) begin
      if (bus.paddr == ID_ADDR)                          dec_set = bus.pwrite ? DEC_ERR : DEC_ID;
      else if (bus.paddr == DATA_ADDR)                   dec_set = DEC_DATA;
      else if (bus.paddr == STATUS_ADDR)                 dec_set = bus.pwrite ? DEC_ERR : DEC_STATUS;
      else if ((bus.paddr & ~SPAN_MASK) == MEM_BASE)     dec_set = DEC_MEM;
    end
  end

  assign idx_set = IDX_W'((bus.paddr - MEM_BASE) >> ALIGN_W);

  always_comb begin
    data_merged = data_q;
    for (int b = 0; b < BYTES; b++) begin
      if (strb_q[b]) data_merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    setup    = bus.psel && !bus.penable;
    complete = 1'b0;
    abort    = 1'b0;
    ram_rd   = 1'b0;
    ram_we   = 1'b0;
    case (state_q)
      IDLE, DONE: state_d = setup ? ACCESS : IDLE;
      ACCESS: begin
        if (!bus.psel) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (pready_q) begin
          complete = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // RAM read is issued the edge before pready so rdata lands in the pready cycle
    ram_rd = (state_q == ACCESS) && bus.psel && !pready_q && (cnt_q == CNT_W'(1))
             && (dec_q == DEC_MEM) && !write_q;
    ram_we = complete && (dec_q == DEC_MEM) && write_q;
    ram_en = ram_rd || ram_we;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= DEC_ERR;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      prdata_q  <= '0;
      data_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      prdata_q  <= '0;

      if ((state_q == IDLE || state_q == DONE) && setup) begin
        dec_q   <= dec_set;
        write_q <= bus.pwrite;
        wdata_q <= bus.pwdata;
        strb_q  <= bus.pstrb;
        idx_q   <= idx_set;
        if (dec_set == DEC_MEM) begin
          cnt_q <= CNT_W'(MEM_WAIT + 1);
        end else begin
          cnt_q     <= '0;
          pready_q  <= 1'b1;
          pslverr_q <= (dec_set == DEC_ERR);
          if (!bus.pwrite) begin
            case (dec_set)
              DEC_ID:     prdata_q <= ID_VALUE;
              DEC_DATA:   prdata_q <= data_q;
              DEC_STATUS: prdata_q <= DATA_W'(err_cnt_q);
              default:    prdata_q <= '0;
            endcase
          end
        end
      end else if (state_q == ACCESS && bus.psel && !pready_q) begin
        if (cnt_q == CNT_W'(1)) begin
          pready_q <= 1'b1;
          mem_rd_q <= !write_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end else if (abort) begin
        cnt_q <= '0;
      end

      if (complete) begin
        case (dec_q)
          DEC_DATA:   if (write_q) data_q <= data_merged;
          DEC_STATUS: err_cnt_q <= '0;
          DEC_ERR:    err_cnt_q <= sat_inc16(err_cnt_q);
          default:    ;
        endcase
      end
    end
  end

  regmem_sp_ram #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (pclk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (strb_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Gating on pready_q makes every output fall with the asynchronous reset
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = pready_q ? (mem_rd_q ? ram_rdata : prdata_q) : '0;

endmodule
